// File: rtl/baby_display_pkg.sv
// Shared timing defaults, store geometry and pipeline stage type for the Baby CRT scanner.
package baby_display_pkg;
    localparam int H_ACTIVE_D = 800;
    localparam int H_FP_D     = 40;
    localparam int H_SYNC_D   = 128;
    localparam int H_BP_D     = 88;
    localparam int V_ACTIVE_D = 600;
    localparam int V_FP_D     = 1;
    localparam int V_SYNC_D   = 4;
    localparam int V_BP_D     = 23;
    localparam int ORIGIN_X_D = 144;
    localparam int ORIGIN_Y_D = 44;

    localparam int CELL_SIZE   = 16;
    localparam int STORE_LINES = 32;
    localparam int WORD_BITS   = 32;
    localparam int WIN_SIZE    = CELL_SIZE * STORE_LINES;
    localparam int CNT_W       = 11;

    typedef logic [WORD_BITS-1:0] store_word_t;
    typedef logic [3:0]           cell_coord_t;
    typedef logic [4:0]           line_t;

    typedef struct packed {
        line_t       col;
        cell_coord_t mx;
        cell_coord_t my;
        logic        win;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } stage_t;

    localparam stage_t STAGE_RST = '{col: '0, mx: '0, my: '0, win: 1'b0,
                                     hs: 1'b0, vs: 1'b0, bl: 1'b1, fs: 1'b0};

    function automatic logic in_span(input logic [CNT_W-1:0] c, input int lo, input int len);
        return (c >= CNT_W'(lo)) && (c < CNT_W'(lo + len));
    endfunction
endpackage

// File: rtl/display_timing.sv
// Free-running h/v raster counters with raw (active-high) sync, blank and frame-start flags.
module display_timing
    import baby_display_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             hs_act,
    output logic             vs_act,
    output logic             blank,
    output logic             frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == CNT_W'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign hs_act      = in_span(h, H_ACTIVE + H_FP, H_SYNC);
    assign vs_act      = in_span(v, V_ACTIVE + V_FP, V_SYNC);
    assign blank       = !((h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE)));
    assign frame_start = (h == '0) && (v == '0);
endmodule

// File: rtl/store_raster_scanner.sv
// Maps the raster onto the 32x32 Baby store window and muxes dot-mask ROM pixels by store bit.
// Optional BABY_ACTION_LINE_EN adds action_line input: that store line is shown inverted.
module store_raster_scanner
    import baby_display_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int ORIGIN_X = ORIGIN_X_D,
    parameter int ORIGIN_Y = ORIGIN_Y_D,
    parameter int SYNC_POL = 1
) (
    input  logic        clk,
    input  logic        reset,
    output line_t       store_addr,
    input  store_word_t store_data,
    output cell_coord_t mask_x,
    output cell_coord_t mask_y,
    input  logic        dot_on_pixel,
    input  logic        dot_off_pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        video,
    output logic        frame_start
`ifdef BABY_ACTION_LINE_EN
    ,
    input  line_t       action_line
`endif
);
    localparam logic POL = (SYNC_POL != 0);

    logic [CNT_W-1:0] h, v, dx, dy;
    logic             hs_raw, vs_raw, bl_raw, fs_raw;
    stage_t           cur, s1, s2;
    logic [1:0]       vld_pipe;
    logic             pix, vid_pix;

    display_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .reset(reset), .h(h), .v(v),
        .hs_act(hs_raw), .vs_act(vs_raw), .blank(bl_raw), .frame_start(fs_raw)
    );

    // Offsets wrap modulo 2^CNT_W, so pixels left of/above the origin fall outside the window.
    assign dx  = h - CNT_W'(ORIGIN_X);
    assign dy  = v - CNT_W'(ORIGIN_Y);
    assign cur = '{col: dx[8:4], mx: dx[3:0], my: dy[3:0],
                   win: (dx < CNT_W'(WIN_SIZE)) && (dy < CNT_W'(WIN_SIZE)),
                   hs: hs_raw, vs: vs_raw, bl: bl_raw, fs: fs_raw};

    assign mask_x = s2.mx;
    assign mask_y = s2.my;
    assign pix    = store_data[s2.col] ? dot_on_pixel : dot_off_pixel;

`ifdef BABY_ACTION_LINE_EN
    logic inv2;
    assign vid_pix = pix ^ inv2;
`else
    assign vid_pix = pix;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe    <= '0;
            s1          <= STAGE_RST;
            s2          <= STAGE_RST;
            store_addr  <= '0;
            video       <= 1'b0;
            hsync       <= ~POL;
            vsync       <= ~POL;
            blank       <= 1'b1;
            frame_start <= 1'b0;
`ifdef BABY_ACTION_LINE_EN
            inv2        <= 1'b0;
`endif
        end else begin
            vld_pipe <= {vld_pipe[0], 1'b1};
            s1       <= cur;
            if (cur.win)
                store_addr <= dy[8:4];
            s2       <= s1;
`ifdef BABY_ACTION_LINE_EN
            inv2     <= (store_addr == action_line);
`endif
            video       <= vld_pipe[1] & s2.win & ~s2.bl & vid_pix;
            hsync       <= POL ? s2.hs : ~s2.hs;
            vsync       <= POL ? s2.vs : ~s2.vs;
            blank       <= s2.bl;
            frame_start <= vld_pipe[1] & s2.fs;
        end
    end
endmodule
